id_ex_reg: RTL
==============

# id_ex_reg

ID/EX pipeline register for the 5-stage RISC-V core, with integrated load-use hazard detection and bubble insertion. It captures the decoded instruction from ID and presents it to the EX stage. Its outputs include `ex_alu_op` and `ex_func`, which drive ALU control, and the operands, which drive the ALU. When EX holds a load whose destination is a source of the instruction in ID, the block asserts a stall to PC and IF/ID and inserts one bubble. It also keeps a saturating count of inserted bubbles.

## Interface
- `XLEN`, 32, datapath width
- `CNT_W`, 16, bubble counter width

Ports:
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `flush` in 1: branch/jump redirect; kill the instruction being loaded
- `hold` in 1: downstream stall; freeze the register contents
- `id_valid` in 1: ID holds a real instruction
- `id_pc` in XLEN: PC of the ID instruction
- `id_rs1_data`, `id_rs2_data`, `id_imm` in XLEN: operands and immediate
- `id_rs1`, `id_rs2`, `id_rd` in 5: register indices
- `id_alu_op` in 2: 00 add, 01 sub/branch, 10 R-type decode
- `id_func` in 4: {funct7[5], funct3}
- `id_alu_src`, `id_mem_read`, `id_mem_write`, `id_reg_write`, `id_mem_to_reg`, `id_branch` in 1: control bits
- `ex_valid` out 1, plus `ex_*` out: registered copy of every `id_*` input above, with the same widths
- `load_use_stall` out 1: combinational; when high, PC and IF/ID must hold
- `bubble_cnt` out CNT_W: number of bubbles inserted, saturating

## Operation
- Control group: valid, alu_op, func, alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch.
- Data group: pc, rs1_data, rs2_data, imm, rs1, rs2, rd.
- Hazard term `haz` is 1 when all of the following hold:
  - `ex_valid`, `ex_mem_read` and `id_valid` are all 1
  - `ex_rd` is not 0
  - `ex_rd` equals `id_rs1` or `id_rs2`
- The comparison is conservative: rs2 is always compared, including for I-type instructions.
- `load_use_stall` = `haz` & ~`flush` & ~`hold`.
- Per-edge action, in priority order:
  1. `flush`: load a bubble (all control bits 0, `ex_alu_op`=00, `ex_func`=0000). The data group may load anything; ID data is loaded.
  2. `hold`: all `ex_*` outputs keep their values.
  3. `haz`: load a bubble; the data group keeps its previous value. `bubble_cnt` increments.
  4. Otherwise: load all `id_*` into `ex_*`.
- If `id_valid`=0 during a normal load, the control group must be loaded as a bubble (all 0), whatever the other `id_*` control bits are.
- `bubble_cnt` increments only on case 3. It saturates at 2^CNT_W−1 and does not wrap.
- A flush has no effect on `bubble_cnt`. A flush during `haz` produces no stall and no count.

## Timing
- Asynchronous reset: on `rst_n`=0, every `ex_*` output and `bubble_cnt` goes to 0 immediately, and `load_use_stall` evaluates to 0. Registers update on the first rising edge after `rst_n` deasserts.
- Reset asserted mid-stall clears the pending bubble; no count is recorded for it.
- Latency is 1 cycle from ID to EX.
- `load_use_stall` is combinational in the same cycle that `haz` is true. It lasts exactly one cycle per load-use pair, because the next cycle EX holds a bubble (`ex_mem_read`=0).
- Back-to-back loads feeding each other stall once per dependent pair.
- `hold` and `flush` in the same cycle: `flush` wins.
- No combinational path from `id_*` to `ex_*`.

## Test plan
- Reset: set all `id_*` nonzero and pulse `rst_n` low mid-cycle → all `ex_*`=0 and `bubble_cnt`=0 immediately, without waiting for a clock edge.
- Normal flow: `id_pc`=0x100, `id_alu_op`=10, `id_func`=1000, `id_rd`=5 → after one edge `ex_pc`=0x100, `ex_alu_op`=10, `ex_func`=1000, `ex_rd`=5, `ex_valid`=1.
- Load-use: EX holds `lw x5` (`ex_mem_read`=1, `ex_rd`=5) and ID has `id_rs2`=5 → `load_use_stall`=1 for one cycle, next `ex_valid`=0 and `ex_mem_read`=0, `bubble_cnt`=1. With ID held, the following edge loads the dependent instruction and stall=0.
- x0 destination: load with `ex_rd`=0 and `id_rs1`=0 → `load_use_stall`=0 and no bubble.
- Flush vs hold vs hazard: `flush`=1, `hold`=1, `haz` true together → bubble loaded, `load_use_stall`=0, `bubble_cnt` unchanged. `hold` alone → `ex_*` unchanged over 3 cycles.
- Saturation: with CNT_W=4, force 20 load-use pairs → `bubble_cnt` reaches 15 and stays at 15.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of inserted bubbles.
module id_ex_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             hold,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [1:0]       id_alu_op,
    input  logic [3:0]       id_func,
    input  logic             id_alu_src,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [1:0]       ex_alu_op,
    output logic [3:0]       ex_func,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic             ex_branch,
    output logic             load_use_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic haz;

    // rs2 is compared even for I-type instructions: a spurious stall is harmless.
    assign haz = ex_valid & ex_mem_read & id_valid & (ex_rd != 5'd0) &
                 ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    assign load_use_stall = haz & ~flush & ~hold;

    // Control group: bubble on flush or hazard, frozen on hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_func       <= 4'b0000;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
        end else if (flush || (!hold && haz)) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_func       <= 4'b0000;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
        end else if (!hold) begin
            // An invalid ID slot enters EX as a bubble regardless of its decode.
            ex_valid      <= id_valid;
            ex_alu_op     <= id_alu_op & {2{id_valid}};
            ex_func       <= id_func & {4{id_valid}};
            ex_alu_src    <= id_alu_src & id_valid;
            ex_mem_read   <= id_mem_read & id_valid;
            ex_mem_write  <= id_mem_write & id_valid;
            ex_reg_write  <= id_reg_write & id_valid;
            ex_mem_to_reg <= id_mem_to_reg & id_valid;
            ex_branch     <= id_branch & id_valid;
        end
    end

    // Data group: a hazard bubble keeps the previous operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
        end else if (flush || (!hold && !haz)) begin
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (load_use_stall && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule
